// File: rtl/int_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : int_arbiter
// Brief    : Four-source round-robin interrupt arbiter with payload capture,
//            overflow flags and a service watchdog.
// Revision : 1.0
// ============================================================================
module int_arbiter #(
    parameter int WD_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] src_data,
    input  logic [3:0]  mask,
    input  logic        int_ack,
    input  logic        int_done,
    output logic        ipu_int,
    output logic [3:0]  grid_coord,
    output logic [1:0]  int_src,
    output logic        busy,
    output logic [3:0]  overflow,
    output logic        timeout
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // The counter sits at WD_CYCLES-1 during the last permitted SERVICE cycle.
    localparam logic [15:0] c_wd_last = 16'(WD_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_pend;
    logic [15:0] r_hold;
    logic [1:0]  r_rr;
    logic [15:0] r_wd;
    logic        r_ipu;
    logic [3:0]  r_coord;
    logic [1:0]  r_src;
    logic [3:0]  r_ovf;
    logic        r_timeout;

    logic [3:0]  w_eligible;
    logic [3:0]  w_clr;
    logic [1:0]  w_winner;
    logic [1:0]  w_idx;
    logic        w_found;
    logic        w_grant;
    logic        w_ack_edge;
    logic        w_wd_expire;

    always_comb begin
        w_eligible = r_pend & mask;
        w_winner   = r_rr;
        w_idx      = r_rr;
        w_found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr + 2'(k);
            if (!w_found && w_eligible[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
        w_grant    = (r_state == ST_IDLE) && w_found;
        w_clr      = w_grant ? (4'b0001 << w_winner) : 4'b0000;
        w_ack_edge = (r_state == ST_REQ) && int_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wd_expire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                // A completion on the expiry cycle wins over the watchdog.
                if (int_done) begin
                    w_state_next = ST_IDLE;
                end else if (r_wd == c_wd_last) begin
                    w_state_next = ST_IDLE;
                    w_wd_expire  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= 4'b0000;
            r_hold    <= 16'h0000;
            r_rr      <= 2'd0;
            r_wd      <= 16'd0;
            r_ipu     <= 1'b0;
            r_coord   <= 4'd0;
            r_src     <= 2'd0;
            r_ovf     <= 4'b0000;
            r_timeout <= 1'b0;
        end else begin
            // A new request on the grant edge re-arms the winner without overflow.
            r_pend <= req | (r_pend & ~w_clr);
            r_ovf  <= r_ovf | (req & r_pend & ~w_clr);
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    r_hold[4*i +: 4] <= src_data[4*i +: 4];
                end
            end
            if (w_grant) begin
                r_coord <= r_hold[{w_winner, 2'b00} +: 4];
                r_src   <= w_winner;
                r_rr    <= w_winner + 2'd1;
                r_ipu   <= 1'b1;
            end else if (w_ack_edge) begin
                r_ipu   <= 1'b0;
            end
            if (w_ack_edge) begin
                r_wd <= 16'd0;
            end else if (r_state == ST_SERVICE) begin
                r_wd <= r_wd + 16'd1;
            end
            if (w_wd_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign ipu_int    = r_ipu;
    assign grid_coord = r_coord;
    assign int_src    = r_src;
    assign busy       = (r_state != ST_IDLE);
    assign overflow   = r_ovf;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_int_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_int_arbiter
// Brief    : Self-checking bench for int_arbiter (vector table, corner
//            sequences, randomized run against a reference model).
// Revision : 1.0
// ============================================================================
module tb_int_arbiter;
    localparam int WD = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] src_data;
    logic [3:0]  mask;
    logic        int_ack;
    logic        int_done;
    logic        ipu_int;
    logic [3:0]  grid_coord;
    logic [1:0]  int_src;
    logic        busy;
    logic [3:0]  overflow;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    int_arbiter #(.WD_CYCLES(WD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .src_data   (src_data),
        .mask       (mask),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .ipu_int    (ipu_int),
        .grid_coord (grid_coord),
        .int_src    (int_src),
        .busy       (busy),
        .overflow   (overflow),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: state 0=idle, 1=waiting for ack, 2=in service.
    int       m_state;
    bit [3:0] m_pend;
    int       m_hold [4];
    bit [3:0] m_ovf;
    int       m_rr;
    int       m_wd;
    bit       m_ipu;
    int       m_coord;
    int       m_src;
    bit       m_to;

    function automatic void model_step();
        int w;
        w = -1;
        if (rst) begin
            m_state = 0; m_pend = 4'b0; m_ovf = 4'b0; m_rr = 0; m_wd = 0;
            m_ipu = 1'b0; m_coord = 0; m_src = 0; m_to = 1'b0;
            for (int i = 0; i < 4; i++) m_hold[i] = 0;
            return;
        end
        case (m_state)
            0: begin
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (m_rr + k) % 4;
                    if (w < 0 && m_pend[j] && mask[j]) w = j;
                end
                if (w >= 0) begin
                    m_coord = m_hold[w];
                    m_src   = w;
                    m_rr    = (w + 1) % 4;
                    m_ipu   = 1'b1;
                    m_state = 1;
                    m_pend[w] = 1'b0;
                end
            end
            1: if (int_ack) begin m_state = 2; m_ipu = 1'b0; m_wd = 0; end
            2: begin
                if (int_done) m_state = 0;
                else begin
                    m_wd++;
                    if (m_wd == WD) begin m_state = 0; m_to = 1'b1; end
                end
            end
            default: m_state = 0;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                if (m_pend[i] && i != w) m_ovf[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_hold[i] = int'(src_data[4*i +: 4]);
            end
        end
    endfunction

    function automatic logic [15:0] dut_outs();
        return {3'b000, ipu_int, grid_coord, int_src, busy, overflow, timeout};
    endfunction

    function automatic logic [15:0] model_outs();
        return {3'b000, m_ipu, 4'(m_coord), 2'(m_src), (m_state != 0), m_ovf, m_to};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 1'b0; req = 4'b0; int_ack = 1'b0; int_done = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset", dut_outs(), 16'h0000);
    endtask

    task automatic count_ipu(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            tick();
            if (ipu_int) cnt++;
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  mask;
        logic        ack;
        logic        done;
        logic        ipu;
        logic [3:0]  coord;
        logic [1:0]  src;
        logic        busy;
        logic [3:0]  ovf;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int cnt;
        tbl[0]  = '{4'b0100, 16'h0900, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{4'b0000, 16'h0000, 4'hF, 1'b0, 1'b0, 1'b1, 4'd9, 2'd2, 1'b1, 4'b0000};
        tbl[2]  = '{4'b0000, 16'h0000, 4'hF, 1'b1, 1'b0, 1'b0, 4'd9, 2'd2, 1'b1, 4'b0000};
        tbl[3]  = '{4'b0000, 16'h0000, 4'hF, 1'b0, 1'b0, 1'b0, 4'd9, 2'd2, 1'b1, 4'b0000};
        tbl[4]  = '{4'b0000, 16'h0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'd9, 2'd2, 1'b0, 4'b0000};
        tbl[5]  = '{4'b0000, 16'h0000, 4'hF, 1'b0, 1'b0, 1'b0, 4'd9, 2'd2, 1'b0, 4'b0000};
        tbl[6]  = '{4'b0010, 16'h0030, 4'h0, 1'b0, 1'b0, 1'b0, 4'd9, 2'd2, 1'b0, 4'b0000};
        tbl[7]  = '{4'b0010, 16'h0050, 4'h0, 1'b0, 1'b0, 1'b0, 4'd9, 2'd2, 1'b0, 4'b0010};
        tbl[8]  = '{4'b0000, 16'h0000, 4'hF, 1'b0, 1'b0, 1'b1, 4'd5, 2'd1, 1'b1, 4'b0010};
        tbl[9]  = '{4'b0000, 16'h0000, 4'hF, 1'b1, 1'b0, 1'b0, 4'd5, 2'd1, 1'b1, 4'b0010};
        tbl[10] = '{4'b0000, 16'h0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'd5, 2'd1, 1'b0, 4'b0010};

        mask = 4'hF; src_data = 16'h0000;
        do_reset();

        // Single grant, service, then overflow with payload overwrite.
        for (int r = 0; r < 11; r++) begin
            req = tbl[r].req; src_data = tbl[r].data; mask = tbl[r].mask;
            int_ack = tbl[r].ack; int_done = tbl[r].done;
            tick();
            check($sformatf("vec%0d", r), dut_outs(),
                  {3'b000, tbl[r].ipu, tbl[r].coord, tbl[r].src, tbl[r].busy, tbl[r].ovf, 1'b0});
        end

        // Round-robin drain of four simultaneous requests.
        do_reset();
        mask = 4'hF; req = 4'hF; src_data = 16'h4321;
        tick();
        req = 4'h0;
        for (int g = 0; g < 4; g++) begin
            for (int t = 0; t < 10 && !ipu_int; t++) tick();
            check($sformatf("rr_grant%0d", g), {11'b0, ipu_int, grid_coord, int_src},
                  {11'b0, 1'b1, 4'(g + 1), 2'(g)});
            repeat (3) tick();
            int_ack = 1'b1; tick(); int_ack = 1'b0;
            repeat (2) tick();
            int_done = 1'b1; tick(); int_done = 1'b0;
        end
        count_ipu(20, cnt);
        check("rr_drained", 16'(cnt), 16'd0);

        // Masked source stays pending, then is granted once unmasked.
        do_reset();
        mask = 4'b1110; req = 4'b0001; src_data = 16'h000C;
        tick();
        req = 4'b0;
        count_ipu(50, cnt);
        check("masked_no_int", 16'(cnt), 16'd0);
        mask = 4'hF;
        tick();
        check("unmask_grant", {11'b0, ipu_int, grid_coord, int_src}, {11'b0, 1'b1, 4'hC, 2'd0});
        // Done alongside ack in REQ only reaches SERVICE.
        int_ack = 1'b1; int_done = 1'b1; tick(); quiet();
        check("ack_done_req", {15'b0, busy}, 16'd1);
        int_done = 1'b1; tick(); int_done = 1'b0;
        check("done_to_idle", {15'b0, busy}, 16'd0);

        // Watchdog expiry after WD service cycles.
        do_reset();
        req = 4'b0001; tick(); req = 4'b0;
        tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        repeat (WD - 1) tick();
        check("wd_before", {14'b0, busy, timeout}, 16'b10);
        tick();
        check("wd_expire", {13'b0, busy, timeout, ipu_int}, 16'b010);

        // Done on the expiry cycle takes precedence over the watchdog.
        do_reset();
        req = 4'b0001; tick(); req = 4'b0;
        tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        repeat (WD - 1) tick();
        int_done = 1'b1; tick(); int_done = 1'b0;
        check("wd_done_prec", {14'b0, busy, timeout}, 16'b00);

        // Request on the grant edge re-arms the winner without overflow.
        do_reset();
        req = 4'b0001; src_data = 16'h0007; tick();
        src_data = 16'h0008; tick();
        req = 4'b0;
        check("regrant_edge", {7'b0, ipu_int, grid_coord, overflow}, {7'b0, 1'b1, 4'd7, 4'b0});
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        int_done = 1'b1; tick(); int_done = 1'b0;
        tick();
        check("regrant_next", {7'b0, ipu_int, grid_coord, overflow}, {7'b0, 1'b1, 4'd8, 4'b0});

        // Reset mid-service discards pending sources.
        do_reset();
        req = 4'b1001; src_data = 16'h6003; tick(); req = 4'b0;
        tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_midsvc", dut_outs(), 16'h0000);
        count_ipu(20, cnt);
        check("rst_no_grant", 16'(cnt), 16'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            req      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            src_data = 16'($urandom);
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
            int_ack  = ($urandom_range(0, 2) == 0);
            int_done = ($urandom_range(0, 14) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick();
            check("rand", dut_outs(), model_outs());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/int_arbiter.md
INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 Parameter: WD_CYCLES, default 255, service watchdog limit in clk cycles (range 1..65535).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-source interrupt request, sampled each cycle; source i = req[i].
REQ-005 src_data  input  16  per-source payload; src_data[4i+3:4i] belongs to source i.
REQ-006 mask  input  4  per-source enable; 1 = source may be granted.
REQ-007 int_ack  input  1  processor acknowledge of ipu_int.
REQ-008 int_done  input  1  processor return-from-interrupt, retired in writeback.
REQ-009 ipu_int  output  1  interrupt request to processor fetch stage.
REQ-010 grid_coord  output  4  payload of the granted source, stable from grant until next grant.
REQ-011 int_src  output  2  index of the granted source.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 overflow  output  4  sticky per-source flag: request arrived while that source was already pending.
REQ-014 timeout  output  1  sticky flag: watchdog expired in SERVICE.

Function
REQ-015 Pending register pend[3:0]: req[i]=1 sets pend[i] at the next edge; payload hold register i loads src_data slice i on the same edge.
REQ-016 req[i]=1 while pend[i]=1 sets overflow[i] and overwrites hold register i with the newest payload; pend stays 1.
REQ-017 FSM states: IDLE, REQ, SERVICE; reset state IDLE.
REQ-018 IDLE: if any (pend & mask) bit is set, the edge selects a winner round-robin, starting at pointer rr and incrementing modulo 4 from it.
REQ-019 The same grant edge moves to REQ, sets ipu_int=1, loads grid_coord from hold[winner], loads int_src=winner, clears pend[winner], and sets rr=(winner+1) mod 4.
REQ-020 req[winner]=1 on the grant edge re-sets pend[winner] and does not set overflow; set wins over clear.
REQ-021 Masked pending bits stay pending indefinitely and are not granted; unmasking makes them eligible in the next IDLE cycle.
REQ-022 REQ: ipu_int stays 1 until int_ack is sampled 1; that edge moves to SERVICE and drives ipu_int=0.
REQ-023 SERVICE: int_done sampled 1 moves to IDLE at that edge.
REQ-024 int_ack outside REQ is ignored; int_done outside SERVICE is ignored; int_ack and int_done together in REQ go to SERVICE only.
REQ-025 Watchdog: a 16-bit counter clears on entry to SERVICE and increments each SERVICE cycle.
REQ-026 When the counter reaches WD_CYCLES without int_done, the FSM moves to IDLE and timeout is set; int_done on that same cycle takes precedence and timeout is not set.
REQ-027 The FSM spends at least one cycle in IDLE between services, so grant latency from pend set to ipu_int=1 is at least 1 cycle.
REQ-028 grid_coord and int_src change only on grant edges.
REQ-029 busy = (state != IDLE), combinational from the state register.

Reset
REQ-030 While rst=1, the design forces state=IDLE, pend=0, all hold registers=0, rr=0, watchdog=0, ipu_int=0, grid_coord=0, int_src=0, overflow=0, timeout=0.
REQ-031 rst=1 overrides req, int_ack and int_done in the same cycle.
REQ-032 rst asserted mid-REQ or mid-SERVICE aborts the service with no pending state retained.
REQ-033 overflow and timeout clear only on rst.

Verification
REQ-034 mask=F, pulse req=0100 with src_data[11:8]=9 for 1 cycle -> ipu_int=1 two edges later, int_src=2, grid_coord=9, busy=1.
REQ-035 req=1111 for 1 cycle, ack and done each service 3 cycles later -> grants occur in order 0,1,2,3, then rr=0 and all pend bits are 0.
REQ-036 mask=1110, req=0001 -> no ipu_int for 50 cycles; set mask=1111 -> ipu_int rises on the next edge after the IDLE cycle, int_src=0.
REQ-037 WD_CYCLES=10, grant and ack, never send int_done -> after 10 SERVICE cycles state=IDLE, timeout=1, busy=0.
REQ-038 Source 1 pending, pulse req[1] again with payload 5 -> overflow=0010; later grant gives grid_coord=5.
REQ-039 rst for 1 cycle during SERVICE with pend=1000 -> all outputs return to 0 and no grant follows without a new req.
